// File: rtl/jtframe_lfbuf_scrbuf.sv
// Line scan-out buffer: captures each streamed line into one of two line banks and
// replays the previously captured bank pixel by pixel during active video.
module jtframe_lfbuf_scrbuf #(
    parameter int              HW    = 9,
    parameter int              DW    = 16,
    parameter int              RDLAT = 2,
    parameter logic [DW-1:0]   BLANK = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          lhbl,
    input  logic          lvbl,
    input  logic          scr_we,
    input  logic [HW-1:0] rd_addr,
    input  logic [15:0]   fb_dout,
    output logic [DW-1:0] pxl,
    output logic [HW-1:0] hdump,
    output logic          miss
);
    localparam logic [HW:0] FULL = {1'b1, {HW{1'b0}}};

    logic [RDLAT-1:0]    we_pipe_q, we_pipe_d;
    logic [RDLAT*HW-1:0] addr_pipe_q, addr_pipe_d;
    logic                scr_we_l_q, scr_we_l_d;
    logic                cap_bank_q, cap_bank_d;
    logic                wr_bank_q, wr_bank_d;
    logic [HW:0]         wcnt_q, wcnt_d;
    logic                lhbl_l_q, lhbl_l_d, lhbl_ll_q, lhbl_ll_d;
    logic                lvbl_l_q, lvbl_l_d, lvbl_ll_q, lvbl_ll_d;
    logic [HW-1:0]       hdump_q, hdump_d;
    logic [DW-1:0]       pxl_q, pxl_d;
    logic                miss_q, miss_d;
    logic [DW-1:0]       rd_data_q;
    logic [DW-1:0]       mem [2**(HW+1)];

    logic                we_dly;
    logic [HW-1:0]       addr_dly;
    logic                we_rise;
    logic                swap;

    always_comb begin
        we_dly   = we_pipe_q[RDLAT-1];
        addr_dly = addr_pipe_q[RDLAT*HW-1 -: HW];
        we_rise  = scr_we & ~scr_we_l_q;
        swap     = pxl_cen & lhbl & ~lhbl_l_q;

        // Capture delay line runs every clk so it tracks the memory read latency exactly
        we_pipe_d   = RDLAT'({we_pipe_q, scr_we});
        addr_pipe_d = (RDLAT*HW)'({addr_pipe_q, rd_addr});
        scr_we_l_d  = scr_we;

        wr_bank_d  = wr_bank_q ^ swap;
        // A burst starting on the swap clk belongs to the post-swap write bank
        cap_bank_d = we_rise ? wr_bank_d : cap_bank_q;

        wcnt_d = wcnt_q;
        if (swap || we_rise)
            wcnt_d = '0;
        else if (we_dly && wcnt_q != FULL)
            wcnt_d = wcnt_q + 1'b1;

        miss_d = swap && (wcnt_q != FULL);

        hdump_d = hdump_q;
        if (swap)
            hdump_d = '0;
        else if (pxl_cen && lhbl)
            hdump_d = hdump_q + 1'b1;

        lhbl_l_d  = lhbl_l_q;
        lhbl_ll_d = lhbl_ll_q;
        lvbl_l_d  = lvbl_l_q;
        lvbl_ll_d = lvbl_ll_q;
        pxl_d     = pxl_q;
        if (pxl_cen) begin
            lhbl_l_d  = lhbl;
            lhbl_ll_d = lhbl_l_q;
            lvbl_l_d  = lvbl;
            lvbl_ll_d = lvbl_l_q;
            pxl_d     = (lhbl_ll_q && lvbl_ll_q) ? rd_data_q : BLANK;
        end
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_pipe_q   <= '0;
            addr_pipe_q <= '0;
            scr_we_l_q  <= 1'b0;
            cap_bank_q  <= 1'b0;
            wr_bank_q   <= 1'b0;
            wcnt_q      <= '0;
            lhbl_l_q    <= 1'b0;
            lhbl_ll_q   <= 1'b0;
            lvbl_l_q    <= 1'b0;
            lvbl_ll_q   <= 1'b0;
            hdump_q     <= '0;
            pxl_q       <= BLANK;
            miss_q      <= 1'b0;
        end else begin
            we_pipe_q   <= we_pipe_d;
            addr_pipe_q <= addr_pipe_d;
            scr_we_l_q  <= scr_we_l_d;
            cap_bank_q  <= cap_bank_d;
            wr_bank_q   <= wr_bank_d;
            wcnt_q      <= wcnt_d;
            lhbl_l_q    <= lhbl_l_d;
            lhbl_ll_q   <= lhbl_ll_d;
            lvbl_l_q    <= lvbl_l_d;
            lvbl_ll_q   <= lvbl_ll_d;
            hdump_q     <= hdump_d;
            pxl_q       <= pxl_d;
            miss_q      <= miss_d;
        end
    end

    // NOTE: the line banks and their read register have no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (we_dly)
            mem[{cap_bank_q, addr_dly}] <= fb_dout[DW-1:0];
        if (pxl_cen)
            rd_data_q <= mem[{~wr_bank_q, hdump_q}];
    end

    assign pxl   = pxl_q;
    assign hdump = hdump_q;
    assign miss  = miss_q;

endmodule
